// File: rtl/reg_logic_pipe.sv
// reg_logic_pipe: WIDTH-bit, DEPTH-stage registered bitwise-logic pipeline with valid/ready
// flow control. Stage 1 captures x, y and op; stage 2 holds op(x, y); stages 3..DEPTH delay it.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   in_valid_i   producer offers x_i, y_i, op_i
//   in_ready_o   pipeline accepts this cycle
//   x_i, y_i     operands
//   op_i         00 AND, 01 OR, 10 XOR, 11 NAND
//   out_valid_o  z_o holds a valid result
//   out_ready_i  consumer takes z_o this cycle
//   z_o          result from the last stage
//   count_o      items in flight, 0..DEPTH
module reg_logic_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [WIDTH-1:0]             x_i,
  input  logic [WIDTH-1:0]             y_i,
  input  logic [1:0]                   op_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [WIDTH-1:0]             z_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned CountW = $clog2(DEPTH + 1);

  localparam logic [1:0] OpAnd  = 2'b00;
  localparam logic [1:0] OpOr   = 2'b01;
  localparam logic [1:0] OpXor  = 2'b10;
  localparam logic [1:0] OpNand = 2'b11;

  function automatic logic [WIDTH-1:0] apply_op(input logic [1:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      OpAnd:   r = a & b;
      OpOr:    r = a | b;
      OpXor:   r = a ^ b;
      OpNand:  r = ~(a & b);
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [DEPTH:1]    v_q, v_d;
  logic [DEPTH:1]    rdy;
  logic [WIDTH-1:0]  x_q, y_q;
  logic [1:0]        op_q;
  logic [WIDTH-1:0]  data_q [2:DEPTH];
  logic [CountW-1:0] count_q, count_d;
  logic              in_hs, out_hs;

  // rdy[k]: stage k may load this cycle. A stage is free if it is empty or everything
  // downstream of it drains, so bubbles collapse behind a stalled stage.
  always_comb begin : p_ready
    logic tail;
    tail = out_ready_i;
    rdy  = '0;
    for (int k = int'(DEPTH); k >= 1; k--) begin
      tail   = !v_q[k] | tail;
      rdy[k] = tail;
    end
  end

  assign in_ready_o  = rst_ni & rdy[1];
  assign in_hs       = in_valid_i & in_ready_o;
  assign out_hs      = v_q[DEPTH] & out_ready_i;
  assign out_valid_o = v_q[DEPTH];
  assign z_o         = data_q[DEPTH];
  assign count_o     = count_q;

  always_comb begin
    v_d    = v_q;
    v_d[1] = rdy[1] ? in_valid_i : v_q[1];
    for (int k = 2; k <= int'(DEPTH); k++) begin
      v_d[k] = rdy[k] ? v_q[k-1] : v_q[k];
    end
  end

  always_comb begin
    count_d = count_q;
    case ({in_hs, out_hs})
      2'b10:   count_d = count_q + CountW'(1);
      2'b01:   count_d = count_q - CountW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      op_q    <= '0;
      count_q <= '0;
      for (int k = 2; k <= int'(DEPTH); k++) begin
        data_q[k] <= '0;
      end
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      // op travels with its operands so later op changes never touch an accepted item
      if (in_hs) begin
        x_q  <= x_i;
        y_q  <= y_i;
        op_q <= op_i;
      end
      if (rdy[2] && v_q[1]) begin
        data_q[2] <= apply_op(op_q, x_q, y_q);
      end
      for (int k = 3; k <= int'(DEPTH); k++) begin
        if (rdy[k] && v_q[k-1]) begin
          data_q[k] <= data_q[k-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_logic_pipe.sv
// Directed checks on an 8-bit, 3-stage instance plus a randomised scoreboard run on a
// 32-bit, 5-stage instance.
module tb_reg_logic_pipe;

  logic clk;
  logic rst_n;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_x, a_y, a_z;
  logic [1:0] a_op;
  logic [1:0] a_count;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_x, b_y, b_z;
  logic [1:0]  b_op;
  logic [2:0]  b_count;

  int n_total = 0;
  int n_bad   = 0;

  reg_logic_pipe #(.WIDTH(8), .DEPTH(3)) u_dut_a (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (a_in_valid),
    .in_ready_o  (a_in_ready),
    .x_i         (a_x),
    .y_i         (a_y),
    .op_i        (a_op),
    .out_valid_o (a_out_valid),
    .out_ready_i (a_out_ready),
    .z_o         (a_z),
    .count_o     (a_count)
  );

  reg_logic_pipe #(.WIDTH(32), .DEPTH(5)) u_dut_b (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (b_in_valid),
    .in_ready_o  (b_in_ready),
    .x_i         (b_x),
    .y_i         (b_y),
    .op_i        (b_op),
    .out_valid_o (b_out_valid),
    .out_ready_i (b_out_ready),
    .z_o         (b_z),
    .count_o     (b_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step_cycle;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model32(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  logic [7:0]  z3_tab  [4] = '{8'h30, 8'hFC, 8'hCC, 8'hCF};
  logic [1:0]  cnt3_tab[8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
  logic [7:0]  x4_tab  [4] = '{8'hF0, 8'hF0, 8'hAA, 8'h55};
  logic [7:0]  y4_tab  [4] = '{8'h3C, 8'h3C, 8'h0F, 8'hFF};
  logic [1:0]  op4_tab [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [7:0]  z4_tab  [4] = '{8'h30, 8'hFC, 8'hA5, 8'hAA};
  logic [7:0]  qa[$];
  logic [31:0] qb[$];

  initial begin
    int          acc, emit;
    logic        prev_stall;
    logic [31:0] prev_z;
    logic [7:0]  ea;

    rst_n = 1'b0;
    a_in_valid = 0; a_out_ready = 0; a_x = 0; a_y = 0; a_op = 0;
    b_in_valid = 0; b_out_ready = 0; b_x = 0; b_y = 0; b_op = 0;
    #1;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_z", a_z, 0);
    chk("rst_count", a_count, 0);
    chk("rst_in_ready", a_in_ready, 0);
    #11 rst_n = 1'b1;
    #1;
    chk("rel_in_ready", a_in_ready, 1);

    // Single item, latency DEPTH
    a_out_ready = 1; a_in_valid = 1; a_x = 8'hF0; a_y = 8'h3C; a_op = 2'b00;
    step_cycle();
    a_in_valid = 0;
    a_op = 2'b11;
    chk("t2_c1_valid", a_out_valid, 0);
    chk("t2_c1_count", a_count, 1);
    step_cycle();
    chk("t2_c2_valid", a_out_valid, 0);
    chk("t2_c2_count", a_count, 1);
    step_cycle();
    chk("t2_c3_valid", a_out_valid, 1);
    chk("t2_c3_z", a_z, 8'h30);
    chk("t2_c3_count", a_count, 1);
    step_cycle();
    chk("t2_c4_valid", a_out_valid, 0);
    chk("t2_c4_count", a_count, 0);
    chk("t2_c4_zhold", a_z, 8'h30);

    // Back-to-back, all four ops
    for (int c = 0; c < 8; c++) begin
      a_in_valid = (c < 4);
      a_op = 2'(c);
      a_x = 8'hF0; a_y = 8'h3C;
      #1;
      if (c < 4) chk("t3_in_ready", a_in_ready, 1);
      chk("t3_count", a_count, cnt3_tab[c]);
      chk("t3_out_valid", a_out_valid, (c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) chk("t3_z", a_z, z3_tab[c-3]);
      step_cycle();
    end
    a_in_valid = 0;

    // Backpressure: three fill, fourth waits
    a_out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1; a_x = x4_tab[i]; a_y = y4_tab[i]; a_op = op4_tab[i];
      #1;
      chk("t4_fill_ready", a_in_ready, 1);
      step_cycle();
    end
    a_x = x4_tab[3]; a_y = y4_tab[3]; a_op = op4_tab[3];
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_full_ready", a_in_ready, 0);
      chk("t4_full_count", a_count, 3);
      chk("t4_full_valid", a_out_valid, 1);
      chk("t4_frozen_z", a_z, 8'h30);
      step_cycle();
    end
    a_out_ready = 1;
    #1;
    chk("t4_release_ready", a_in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) #1;
      chk("t4_drain_valid", a_out_valid, 1);
      chk("t4_drain_z", a_z, z4_tab[i]);
      chk("t4_drain_count", a_count, (i < 2) ? 3 : 4 - i);
      step_cycle();
      a_in_valid = 0;
    end
    chk("t4_empty_valid", a_out_valid, 0);
    chk("t4_empty_count", a_count, 0);

    // Full pipe streaming, one in and one out per cycle
    a_out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1; a_x = 8'(i * 16); a_y = 8'h0F; a_op = 2'b10;
      #1;
      chk("t5_fill_ready", a_in_ready, 1);
      qa.push_back(8'(i * 16) ^ 8'h0F);
      step_cycle();
    end
    acc = 0;
    for (int i = 3; i < 13; i++) begin
      a_in_valid = 1; a_out_ready = 1; a_x = 8'(i * 16);
      #1;
      chk("t5_in_ready", a_in_ready, 1);
      chk("t5_out_valid", a_out_valid, 1);
      chk("t5_count", a_count, 3);
      ea = qa.pop_front();
      chk("t5_z", a_z, ea);
      if (a_in_valid && a_in_ready) begin
        qa.push_back(8'(i * 16) ^ 8'h0F);
        acc++;
      end
      step_cycle();
    end
    chk("t5_accepts", acc, 10);
    a_in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_drain_valid", a_out_valid, 1);
      ea = qa.pop_front();
      chk("t5_drain_z", a_z, ea);
      step_cycle();
    end
    chk("t5_end_count", a_count, 0);

    // Reset with two items in flight
    a_out_ready = 0;
    a_in_valid = 1; a_x = 8'h12; a_y = 8'h34; a_op = 2'b01;
    step_cycle();
    a_x = 8'h56;
    step_cycle();
    a_in_valid = 0;
    chk("t1_pre_count", a_count, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_rst_valid", a_out_valid, 0);
    chk("t1_rst_z", a_z, 0);
    chk("t1_rst_count", a_count, 0);
    chk("t1_rst_ready", a_in_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    a_out_ready = 1;
    #1;
    chk("t1_rel_ready", a_in_ready, 1);
    for (int i = 0; i < 5; i++) begin
      step_cycle();
      chk("t1_no_stale", a_out_valid, 0);
      chk("t1_count", a_count, 0);
    end

    // Random traffic on the wide, deep instance
    acc = 0; emit = 0; prev_stall = 0; prev_z = 0;
    for (int c = 0; c < 3000; c++) begin
      b_in_valid  = 1'($urandom_range(0, 1));
      b_out_ready = 1'($urandom_range(0, 1));
      b_x = $urandom; b_y = $urandom; b_op = 2'($urandom_range(0, 3));
      #1;
      if (prev_stall) begin
        chk("b_hold_valid", b_out_valid, 1);
        chk("b_hold_z", b_z, prev_z);
      end
      chk("b_count", b_count, acc - emit);
      if (b_out_valid && b_out_ready) begin
        chk("b_spurious", (qb.size() == 0), 0);
        if (qb.size() > 0) chk("b_z", b_z, qb.pop_front());
        emit++;
      end
      if (b_in_valid && b_in_ready) begin
        qb.push_back(model32(b_op, b_x, b_y));
        acc++;
      end
      prev_stall = b_out_valid && !b_out_ready;
      prev_z = b_z;
      step_cycle();
    end
    b_in_valid = 0; b_out_ready = 1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (b_out_valid) begin
        chk("b_drain_spurious", (qb.size() == 0), 0);
        if (qb.size() > 0) chk("b_drain_z", b_z, qb.pop_front());
      end
      step_cycle();
    end
    chk("b_drained", qb.size(), 0);
    chk("b_final_count", b_count, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
